apb_master_mux: RTL and testbench

Parametrised APB4 master with an integrated N-way slave decoder and response channel. It accepts one transfer at a time from the AXI4-to-APB bridge over a valid/ready request port. It runs the APB SETUP/ACCESS protocol to the addressed slave and returns read data plus a 2-bit status over a valid/ready response port. Compared with the previous master it adds generic slave count, a registered bus, read-strobe masking, decode-error and timeout detection, and response back-pressure.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_addr_decoder.sv | 21 ++
 rtl/apb_master_mux.sv | 194 +++++++++++++++++++
 tb/tb_apb_master_mux.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM state encoding and response status codes.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } apb_state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b01;
  localparam logic [1:0] RESP_DECERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB slave decoder: top address bits -> slave index, one-hot select, hit flag.
module apb_addr_decoder #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_BITS   = 4
) (
  input  logic [SEL_BITS-1:0]   addr_hi,
  output logic [SEL_BITS-1:0]   idx_c,
  output logic [NUM_SLAVES-1:0] sel_c,
  output logic                  hit_c
);

  always_comb begin
    idx_c = addr_hi;
    hit_c = (32'(addr_hi) < NUM_SLAVES);
    sel_c = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_c[i] = hit_c && (32'(addr_hi) == 32'(i));
    end
  end

endmodule

// File: rtl/apb_master_mux.sv
// APB4 master with integrated N-way slave decode, timeout abort and a
// back-pressured response channel; one transfer in flight at a time.
module apb_master_mux
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned SEL_BITS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [DATA_WIDTH/8-1:0]          req_strb,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_err,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  apb_state_e              state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_err_q, rsp_err_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic [SEL_BITS-1:0]     idx_q, idx_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic [SEL_BITS-1:0]     dec_idx;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_hit;
  logic                    acc_ready;
  logic                    acc_slverr;
  logic [DATA_WIDTH-1:0]   acc_rdata;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_BITS   (SEL_BITS)
  ) u_dec (
    .addr_hi (req_addr[ADDR_WIDTH-1 -: SEL_BITS]),
    .idx_c   (dec_idx),
    .sel_c   (dec_sel),
    .hit_c   (dec_hit)
  );

  // Only the selected slave's response lines are observed.
  always_comb begin
    acc_ready  = 1'b0;
    acc_slverr = 1'b0;
    acc_rdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SEL_BITS'(i)) begin
        acc_ready  = PREADY[i];
        acc_slverr = PSLVERR[i];
        acc_rdata  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dec_hit) begin
            state_d  = SETUP;
            paddr_d  = req_addr;
            pwrite_d = req_write;
            pwdata_d = req_wdata;
            pstrb_d  = req_write ? req_strb : '0;
            psel_d   = dec_sel;
            idx_d    = dec_idx;
            cnt_d    = '0;
          end else begin
            state_d     = RESP;
            rsp_rdata_d = '0;
            rsp_err_d   = RESP_DECERR;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (acc_ready) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : acc_rdata;
          rsp_err_d   = acc_slverr ? RESP_SLVERR : RESP_OKAY;
        end else if (TIMEOUT_CYCLES != 0) begin
          // Abort on the TIMEOUT_CYCLES-th consecutive wait cycle.
          if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            state_d     = RESP;
            psel_d      = '0;
            penable_d   = 1'b0;
            rsp_rdata_d = '0;
            rsp_err_d   = RESP_TIMEOUT;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= RESP_OKAY;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_master_mux.sv
// Self-checking bench for apb_master_mux: directed vector table, reset corner case,
// and randomized transfers against a latency/response reference model.
module tb_apb_master_mux;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int SB = 4;
  localparam int TO = 16;
  localparam int NV = 10;

  logic              PCLK;
  logic              PRESETn;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic [DW/8-1:0]   req_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_err;
  logic [NS-1:0]     PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic [DW/8-1:0]   PSTRB;
  logic [NS*DW-1:0]  PRDATA;
  logic [NS-1:0]     PREADY;
  logic [NS-1:0]     PSLVERR;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int last_span = 0;
  bit have_last = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        slverr;
    logic [31:0] rd;
    int          hold;
    int          lat;
    logic [1:0]  err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [NV];

  apb_master_mux #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_SLAVES     (NS),
    .SEL_BITS       (SB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: latency from handshake to rsp_valid, status and read data.
  function automatic void model(input logic wr, input logic [31:0] addr, input int waits,
                                input logic slverr, input logic [31:0] rd,
                                output int lat, output logic [1:0] err, output logic [31:0] rdata);
    int idx;
    idx = int'(addr[31:28]);
    if (idx >= NS) begin
      lat = 1; err = 2'b10; rdata = 32'h0;
    end else if (waits >= TO) begin
      lat = TO + 2; err = 2'b11; rdata = 32'h0;
    end else begin
      lat = waits + 3; err = slverr ? 2'b01 : 2'b00; rdata = wr ? 32'h0 : rd;
    end
  endfunction

  // Random noise on every slave, with the addressed slave's lines overridden.
  task automatic drive_slaves(input int idx, input logic rdy, input logic err, input logic [31:0] rd);
    for (int i = 0; i < NS; i++) begin
      PRDATA[i*DW +: DW] = 32'($urandom);
      PREADY[i]  = 1'($urandom_range(0, 1));
      PSLVERR[i] = 1'($urandom_range(0, 1));
    end
    if (idx < NS) begin
      PREADY[idx]  = rdy;
      PSLVERR[idx] = rdy ? err : 1'($urandom_range(0, 1));
      PRDATA[idx*DW +: DW] = rdy ? rd : 32'($urandom);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
    chk({tag, "_rsp_err"},   64'(rsp_err),   64'(0));
    chk({tag, "_psel"},      64'(PSEL),      64'(0));
    chk({tag, "_penable"},   64'(PENABLE),   64'(0));
    chk({tag, "_pwrite"},    64'(PWRITE),    64'(0));
    chk({tag, "_paddr"},     64'(PADDR),     64'(0));
    chk({tag, "_pwdata"},    64'(PWDATA),    64'(0));
    chk({tag, "_pstrb"},     64'(PSTRB),     64'(0));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int waits, input logic slverr,
                      input logic [31:0] rd, input int hold,
                      input int exp_lat, input logic [1:0] exp_err, input logic [31:0] exp_rdata);
    int idx;
    int got;
    logic [NS-1:0] exp_psel;
    idx = int'(addr[31:28]);
    exp_psel = (idx < NS) ? NS'(1 << idx) : '0;
    chk("req_ready_idle", 64'(req_ready), 64'(1));
    if (have_last) chk("issue_interval", 64'(cyc - last_acc), 64'(last_span));
    last_acc  = cyc;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    rsp_ready = (hold == 0);
    drive_slaves(idx, 1'b0, slverr, rd);
    got = 0;
    for (int n = 1; n <= 40 && got == 0; n++) begin
      @(negedge PCLK);
      req_valid = 1'b0;
      if (rsp_valid) begin
        got = n;
      end else begin
        chk("psel",           64'(PSEL),      64'(exp_psel));
        chk("penable",        64'(PENABLE),   64'(n >= 2));
        chk("paddr",          64'(PADDR),     64'(addr));
        chk("pwrite",         64'(PWRITE),    64'(wr));
        chk("pwdata",         64'(PWDATA),    64'(wdata));
        chk("pstrb",          64'(PSTRB),     64'(wr ? strb : 4'h0));
        chk("req_ready_busy", 64'(req_ready), 64'(0));
        drive_slaves(idx, n == waits + 2, slverr, rd);
      end
    end
    chk("latency", 64'(got), 64'(exp_lat));
    if (got != 0) begin
      chk("rsp_rdata",     64'(rsp_rdata), 64'(exp_rdata));
      chk("rsp_err",       64'(rsp_err),   64'(exp_err));
      chk("rsp_psel_off",  64'(PSEL),      64'(0));
      chk("rsp_pen_off",   64'(PENABLE),   64'(0));
      chk("rsp_req_ready", 64'(req_ready), 64'(0));
      for (int h = 0; h < hold; h++) begin
        @(negedge PCLK);
        chk("hold_valid",     64'(rsp_valid), 64'(1));
        chk("hold_rdata",     64'(rsp_rdata), 64'(exp_rdata));
        chk("hold_err",       64'(rsp_err),   64'(exp_err));
        chk("hold_req_ready", 64'(req_ready), 64'(0));
      end
      rsp_ready = 1'b1;
      @(negedge PCLK);
      chk("rsp_consumed", 64'(rsp_valid), 64'(0));
      chk("back_to_idle", 64'(req_ready), 64'(1));
      last_span = exp_lat + hold + 1;
      have_last = 1;
    end else begin
      PRESETn = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b1;
      have_last = 0;
    end
  endtask

  initial begin
    logic        r_wr;
    logic [3:0]  r_hi;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_strb;
    int          r_waits;
    int          r_sel;
    logic        r_slverr;
    logic [31:0] r_rd;
    int          r_hold;
    int          m_lat;
    logic [1:0]  m_err;
    logic [31:0] m_rdata;

    PRESETn   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    rsp_ready = 1'b1;
    PRDATA    = '0;
    PREADY    = '0;
    PSLVERR   = '0;
    repeat (2) @(negedge PCLK);
    chk_reset("init");
    PRESETn = 1'b1;
    @(negedge PCLK);

    //         wr    addr          wdata         strb  waits slv   rd            hold lat err    rdata
    vecs[0] = '{1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 0,  1'b0, 32'h0BAD_0BAD, 0, 3,  2'b00, 32'h0};
    vecs[1] = '{1'b0, 32'h2000_0004, 32'h0,         4'hF, 3,  1'b0, 32'h1234_5678, 0, 6,  2'b00, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h3000_0000, 32'h0,         4'h0, 1,  1'b1, 32'hCAFE_F00D, 0, 4,  2'b01, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 32'h5000_0000, 32'h1111_2222, 4'hF, 0,  1'b0, 32'h0,         0, 1,  2'b10, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 20, 1'b0, 32'h7777_7777, 0, 18, 2'b11, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 0,  1'b0, 32'h0000_A5A5, 5, 3,  2'b00, 32'h0000_A5A5};
    vecs[6] = '{1'b1, 32'h2000_0008, 32'h5555_AAAA, 4'h3, 2,  1'b1, 32'h0,         0, 5,  2'b01, 32'h0};
    vecs[7] = '{1'b0, 32'hF000_0000, 32'h0,         4'h0, 0,  1'b0, 32'h0,         2, 1,  2'b10, 32'h0};
    vecs[8] = '{1'b1, 32'h1000_0000, 32'h0102_0304, 4'h5, 15, 1'b0, 32'h0,         0, 18, 2'b00, 32'h0};
    vecs[9] = '{1'b0, 32'h3000_0000, 32'h0,         4'h0, 16, 1'b0, 32'h9999_9999, 0, 18, 2'b11, 32'h0};

    for (int v = 0; v < NV; v++) begin
      xfer(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, vecs[v].waits,
           vecs[v].slverr, vecs[v].rd, vecs[v].hold, vecs[v].lat, vecs[v].err, vecs[v].rdata);
    end

    // Reset asserted while the slave holds the bus in ACCESS.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0100;
    req_wdata = 32'h1122_3344;
    req_strb  = 4'hF;
    PREADY    = '0;
    PSLVERR   = '0;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    chk("rst_pre_penable", 64'(PENABLE), 64'(1));
    chk("rst_pre_paddr",   64'(PADDR),   64'(32'h0000_0100));
    #2;
    PRESETn = 1'b0;
    #1;
    chk_reset("async_rst");
    @(negedge PCLK);
    PRESETn = 1'b1;
    PREADY  = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge PCLK);
      chk("post_rst_no_rsp",  64'(rsp_valid), 64'(0));
      chk("post_rst_no_psel", 64'(PSEL),      64'(0));
      chk("post_rst_ready",   64'(req_ready), 64'(1));
    end
    have_last = 0;
    xfer(1'b0, 32'h1000_0020, 32'h0, 4'h0, 0, 1'b0, 32'h600D_CAFE, 0, 3, 2'b00, 32'h600D_CAFE);

    // Randomized transfers against the reference model.
    for (int t = 0; t < 40; t++) begin
      r_hi     = 4'($urandom_range(0, 5));
      r_addr   = {r_hi, 28'($urandom)};
      r_wr     = 1'($urandom_range(0, 1));
      r_wdata  = 32'($urandom);
      r_strb   = 4'($urandom);
      r_sel    = int'($urandom_range(0, 9));
      if (r_sel < 7)       r_waits = int'($urandom_range(0, 4));
      else if (r_sel == 7) r_waits = TO - 1;
      else                 r_waits = int'($urandom_range(TO, TO + 2));
      r_slverr = 1'($urandom_range(0, 1));
      r_rd     = 32'($urandom);
      r_hold   = int'($urandom_range(0, 3));
      model(r_wr, r_addr, r_waits, r_slverr, r_rd, m_lat, m_err, m_rdata);
      xfer(r_wr, r_addr, r_wdata, r_strb, r_waits, r_slverr, r_rd, r_hold, m_lat, m_err, m_rdata);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
